// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding request to instruction memory,
// 2-entry {pc, instr} buffer toward the decoder, redirect flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [1:0]  fsm_state,
    output logic [1:0]  fifo_count
);

    // Handshakes: the decoder takes the head entry on a rising edge where
    // instr_valid && instr_ready; memory requests stay up (address frozen)
    // until an edge where imem_req && imem_rvalid, which ends the request.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    state_t      state_next;
    logic        armed;
    logic [31:0] fetch_pc;
    logic [31:0] addr_q;
    logic [1:0]  count;
    logic [31:0] pc_q  [2];
    logic [31:0] ins_q [2];

    logic issue;
    logic push;
    logic pop;
    logic unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        pop        = (count != 2'd0) && instr_ready && !redirect;
        case (state)
            IDLE: begin
                if (armed && !redirect && (count < 2'd2)) begin
                    state_next = WAIT;
                    issue      = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                    push       = !redirect;
                end else if (redirect) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // armed delays the first request by one cycle after reset release so
    // that fetching never starts on the edge that also sees reset leave.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
        end else begin
            armed <= 1'b1;
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (issue) begin
                addr_q <= fetch_pc;
            end
        end
    end

    // Shift FIFO: slot 0 is always the head; a push never sees count == 2
    // because a request only issues with room left and only one is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 2'd0;
            pc_q[0]  <= 32'd0;
            pc_q[1]  <= 32'd0;
            ins_q[0] <= NOP;
            ins_q[1] <= NOP;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    pc_q[count[0]]  <= fetch_pc;
                    ins_q[count[0]] <= imem_rdata;
                    count           <= count + 2'd1;
                end
                2'b01: begin
                    pc_q[0]  <= pc_q[1];
                    ins_q[0] <= ins_q[1];
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        pc_q[0]  <= fetch_pc;
                        ins_q[0] <= imem_rdata;
                    end else begin
                        pc_q[0]  <= pc_q[1];
                        ins_q[0] <= ins_q[1];
                        pc_q[1]  <= fetch_pc;
                        ins_q[1] <= imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (state != IDLE);
    assign imem_addr   = addr_q;
    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? ins_q[0] : NOP;
    assign instr_pc    = instr_valid ? pc_q[0] : 32'd0;
    assign fsm_state   = state;
    assign fifo_count  = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory
// responder that returns ~address as the instruction word.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [1:0]  fsm_state;
    logic [1:0]  fifo_count;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic        hi_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_pc;
    logic [1:0]  hi_state;
    logic [1:0]  hi_count;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    int wait_cnt = 0;
    int rsp_cnt  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fsm_state   (fsm_state),
        .fifo_count  (fifo_count)
    );

    // Same stimulus as dut, so its timing is identical; only addresses differ.
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (hi_req),
        .imem_addr   (hi_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (hi_valid),
        .instr       (hi_instr),
        .instr_pc    (hi_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fsm_state   (hi_state),
        .fifo_count  (hi_count)
    );

    // Memory: rvalid pulses for one cycle once the request has been up for
    // mem_lat cycles.
    always @(negedge clk) begin
        if (!reset) begin
            imem_rvalid = 1'b0;
            wait_cnt    = 0;
        end else if (imem_rvalid) begin
            imem_rvalid = 1'b0;
            wait_cnt    = 0;
        end else if (imem_req) begin
            wait_cnt = wait_cnt + 1;
            if (wait_cnt >= mem_lat) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~imem_addr;
                rsp_cnt     = rsp_cnt + 1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        @(negedge clk);
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = rdy;
        mem_lat     = lat;
        rsp_cnt     = 0;
        @(negedge clk);
        check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr",  imem_addr, 32'd0);
        check_eq("rst_haddr", hi_addr, 32'hFFFF_FFF8);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_pc",    instr_pc, 32'd0);
        check_eq("rst_state", {30'd0, fsm_state}, 32'd0);
        check_eq("rst_count", {30'd0, fifo_count}, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        int          seen_valid;
        logic [31:0] e;

        reset       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        // Streaming with 1-cycle memory; also the wrap case on dut_hi.
        do_reset(1, 1'b1);
        step(1);
        check_eq("arm_req", {31'd0, imem_req}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            e = 32'(4 * k);
            step(1);
            check_eq("s_req",   {31'd0, imem_req}, 32'd1);
            check_eq("s_addr",  imem_addr, e);
            check_eq("hi_addr", hi_addr, 32'hFFFF_FFF8 + e);
            step(1);
            check_eq("s_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("s_pc",    instr_pc, e);
            check_eq("s_instr", instr, ~e);
            check_eq("hi_pc",   hi_pc, 32'hFFFF_FFF8 + e);
        end

        // Back-pressure: two entries buffered, then drained in order.
        do_reset(1, 1'b0);
        step(20);
        check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("bp_pc",    instr_pc, 32'h0);
        check_eq("bp_instr", instr, 32'hFFFF_FFFF);
        check_eq("bp_count", {30'd0, fifo_count}, 32'd2);
        check_eq("bp_req",   {31'd0, imem_req}, 32'd0);
        check_eq("bp_nrsp",  rsp_cnt, 32'd2);
        instr_ready = 1'b1;
        step(1);
        check_eq("dr_pc",    instr_pc, 32'h4);
        check_eq("dr_instr", instr, ~32'h4);
        check_eq("dr_req",   {31'd0, imem_req}, 32'd0);
        step(1);
        check_eq("dr_empty", {31'd0, instr_valid}, 32'd0);
        check_eq("dr_req2",  {31'd0, imem_req}, 32'd1);
        check_eq("dr_addr",  imem_addr, 32'h8);

        // Redirect with a full buffer; low address bits dropped.
        do_reset(1, 1'b0);
        step(10);
        check_eq("rf_count", {30'd0, fifo_count}, 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step(1);
        redirect = 1'b0;
        check_eq("rf_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rf_count0", {30'd0, fifo_count}, 32'd0);
        check_eq("rf_req",   {31'd0, imem_req}, 32'd0);
        step(1);
        check_eq("rf_req1",  {31'd0, imem_req}, 32'd1);
        check_eq("rf_addr",  imem_addr, 32'h100);
        step(1);
        check_eq("rf_pc",    instr_pc, 32'h100);
        check_eq("rf_instr", instr, ~32'h100);

        // Redirect during a slow request: stale response is discarded.
        do_reset(5, 1'b1);
        step(3);
        check_eq("dw_req",  {31'd0, imem_req}, 32'd1);
        check_eq("dw_addr", imem_addr, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step(1);
        redirect = 1'b0;
        check_eq("dw_state", {30'd0, fsm_state}, 32'd2);
        check_eq("dw_hold",  imem_addr, 32'h0);
        waited     = -1;
        seen_valid = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (instr_valid) seen_valid = 1;
            if (imem_req && imem_addr == 32'h200) begin
                waited = i;
                break;
            end
        end
        check_eq("dw_wait",  waited, 32'd4);
        check_eq("dw_stale", rsp_cnt, 32'd1);
        check_eq("dw_novld", seen_valid, 32'd0);
        waited = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (instr_valid) begin
                waited = i;
                break;
            end
        end
        check_eq("dw_wait2", waited, 32'd5);
        check_eq("dw_pc",    instr_pc, 32'h200);
        check_eq("dw_instr", instr, ~32'h200);

        // Redirect coincident with a response and a pop.
        do_reset(1, 1'b0);
        step(4);
        check_eq("cx_count", {30'd0, fifo_count}, 32'd1);
        check_eq("cx_addr",  imem_addr, 32'h4);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        instr_ready = 1'b1;
        step(1);
        redirect = 1'b0;
        check_eq("cx_count0", {30'd0, fifo_count}, 32'd0);
        check_eq("cx_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("cx_state", {30'd0, fsm_state}, 32'd0);
        step(1);
        check_eq("cx_req",   {31'd0, imem_req}, 32'd1);
        check_eq("cx_taddr", imem_addr, 32'h300);
        step(1);
        check_eq("cx_pc",    instr_pc, 32'h300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be 00.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-004 imem_req  output  1  instruction-memory request; held high until the response.
REQ-005 imem_addr  output  32  word-aligned fetch address; stable while imem_req is high.
REQ-006 imem_rvalid  input  1  memory response strobe; ignored unless imem_req is high.
REQ-007 imem_rdata  input  32  fetched instruction; valid with imem_rvalid.
REQ-008 instr_valid  output  1  buffered instruction available to the decoder.
REQ-009 instr  output  32  head-of-buffer instruction; 32'h0000_0013 (nop) when instr_valid is low.
REQ-010 instr_pc  output  32  address of instr; 0 when instr_valid is low.
REQ-011 instr_ready  input  1  decoder accepts the head entry when instr_valid and instr_ready are both high.
REQ-012 redirect  input  1  taken branch, jal or jalr: flush and refetch.
REQ-013 redirect_pc  input  32  redirect target; bits [1:0] SHALL be ignored and treated as 00.

Function
REQ-014 The block SHALL hold a 2-entry FIFO of {pc, instr} pairs and a fetch_pc register; instr_valid SHALL equal (count != 0), driven combinationally from the head entry.
REQ-015 FSM states SHALL be IDLE (no request), WAIT (request outstanding) and DISCARD (outstanding response to be dropped); there SHALL be at most one outstanding request.
REQ-016 IDLE -> WAIT when count < 2 and redirect is low; entering WAIT, imem_req SHALL rise the next cycle with imem_addr = fetch_pc.
REQ-017 WAIT with imem_rvalid high and redirect low: the FSM SHALL push {fetch_pc, imem_rdata}, set fetch_pc += 4 (mod 2^32, wrapping 32'hFFFF_FFFC -> 0), and go to IDLE.
REQ-018 Memory response latency SHALL be unbounded (>= 1 cycle after imem_req rises); imem_req and imem_addr SHALL NOT change before imem_rvalid.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and preserve order; a pop with count = 0 SHALL have no effect.
REQ-020 A push SHALL never overflow, because a request issues only when count < 2 and a single request is outstanding.
REQ-021 Redirect SHALL take priority in every state: the FIFO empties, count = 0, and fetch_pc = {redirect_pc[31:2], 2'b00} on the same edge, and a simultaneous pop SHALL be ignored.
REQ-022 Redirect in IDLE: next state SHALL be IDLE; a fetch of the new fetch_pc SHALL be issued on the following cycle.
REQ-023 Redirect in WAIT without imem_rvalid: the FSM SHALL enter DISCARD, keep imem_req high with the old imem_addr, and drop the response; on imem_rvalid it SHALL go to IDLE with no push.
REQ-024 Redirect in WAIT with imem_rvalid in the same cycle: the response SHALL be dropped and the FSM SHALL go to IDLE.
REQ-025 Redirect in DISCARD: fetch_pc SHALL update and the FSM SHALL stay in DISCARD until imem_rvalid.
REQ-026 Best-case throughput SHALL be 1 instruction per 2 cycles with a 1-cycle memory; latency from imem_rvalid to instr_valid SHALL be 1 cycle.

Reset
REQ-027 While reset is low, outputs SHALL be: imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 32'h0000_0013, instr_pc = 0; state SHALL be IDLE, count = 0, fetch_pc = RESET_PC.
REQ-028 Reset asserted mid-WAIT or mid-DISCARD SHALL abandon the outstanding request; a later imem_rvalid received while imem_req is low SHALL be ignored.
REQ-029 The first imem_req SHALL assert on the second rising edge after reset deasserts, with imem_addr = RESET_PC.

Verification
REQ-030 Reset release, 1-cycle memory returning addr-tagged data, instr_ready = 1 -> instr_pc sequence 0x0, 0x4, 0x8, each instr_valid one cycle after its imem_rvalid.
REQ-031 instr_ready = 0 for 20 cycles -> exactly two entries (pc 0x0, 0x4) buffered and imem_req stays low; raising instr_ready drains 0x0 then 0x4 and fetching resumes at 0x8.
REQ-032 redirect with redirect_pc = 0x103 while count = 2 -> instr_valid low next cycle, next imem_addr = 0x100.
REQ-033 redirect during WAIT with memory latency 5 -> the stale response is never output; the next request is to the redirect target and is issued only after the stale imem_rvalid.
REQ-034 redirect coincident with imem_rvalid and an instr_ready pop -> no push, count = 0, next fetch is to the target.
REQ-035 RESET_PC = 32'hFFFF_FFF8 -> fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
